// File: rtl/writeback_unit.sv
// -----------------------------------------------------------------------------
// writeback_unit
//
// Write-back stage for the Pillar core. Execute results are accepted on a
// valid/ready handshake into a DEPTH-entry in-order circular buffer. The head
// entry retires one per cycle (unless the register file stalls or a flush is
// in progress), producing a registered register-file write and a next-PC value.
//
// Parameters:
//   XLEN     datapath and PC width
//   DEPTH    buffer entries (power of two, >= 2)
//   PC_STEP  increment applied to a retired PC (word-indexed)
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset      synchronous active-low reset
//   in_valid   execute presents an entry
//   in_ready   buffer can accept (count != DEPTH, registered-state only)
//   in_data    result to write back
//   in_pc      PC of the instruction
//   in_ir      instruction word
//   rf_stall   register file busy; head is held
//   flush      discard all buffered entries (drops a same-cycle push)
//   rf_we      register-file write enable pulse
//   rf_rd      destination register of the retired entry
//   rf_wd      write data of the retired entry
//   pc_valid   pulse per retired entry
//   pc_o       next PC of the retired entry (0 for an illegal opcode)
//   illegal_o  pulse when the retired opcode is unsupported
//   count      current buffer occupancy
//   retired_o  (WB_RETIRE_CNT_EN only) pops since reset, wraps at 2^32
//
// Optional feature macro: WB_RETIRE_CNT_EN
// -----------------------------------------------------------------------------

// Opcode decode values normally supplied by opcode.v; guarded so a build that
// already includes opcode.v keeps its definitions.
`ifndef DECODE_R_TYPE
`define DECODE_R_TYPE 7'b0110011
`endif
`ifndef DECODE_I_TYPE
`define DECODE_I_TYPE 7'b0010011
`endif

module writeback_unit #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 4,
    parameter int PC_STEP = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_data,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [31:0]                in_ir,
    input  logic                       rf_stall,
    input  logic                       flush,
    output logic                       rf_we,
    output logic [4:0]                 rf_rd,
    output logic [XLEN-1:0]            rf_wd,
    output logic                       pc_valid,
    output logic [XLEN-1:0]            pc_o,
    output logic                       illegal_o,
`ifdef WB_RETIRE_CNT_EN
    output logic [31:0]                retired_o,
`endif
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // Entry storage
    logic [XLEN-1:0] mem_data [DEPTH];
    logic [XLEN-1:0] mem_pc   [DEPTH];
    logic [31:0]     mem_ir   [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic push;
    logic pop;

    // Head entry and its decode
    logic [XLEN-1:0] head_data;
    logic [XLEN-1:0] head_pc;
    logic [31:0]     head_ir;
    logic            head_legal;
    logic            head_we;
    logic [XLEN-1:0] head_next_pc;

    // Upper instruction bits are carried in the buffer but not needed here.
    logic unused_ir_bits;

    // Ready looks only at registered occupancy: no path from rf_stall/in_valid.
    assign in_ready = (count != FULL);

    // Flush wins over both a push and a pop in the same cycle.
    assign push = in_valid && in_ready && !flush;
    assign pop  = !rf_stall && (count != '0) && !flush;

    assign head_data = mem_data[rd_ptr];
    assign head_pc   = mem_pc[rd_ptr];
    assign head_ir   = mem_ir[rd_ptr];

    assign unused_ir_bits = ^head_ir[31:12];

    // NOTE: every signal driven in always_comb gets a default first, so no
    // path through the block leaves it unassigned and a latch is never inferred.
    always_comb begin
        head_legal   = 1'b0;
        head_we      = 1'b0;
        head_next_pc = '0;
        if ((head_ir[6:0] == `DECODE_R_TYPE) || (head_ir[6:0] == `DECODE_I_TYPE)) begin
            head_legal   = 1'b1;
            head_we      = (head_ir[11:7] != 5'd0);
            head_next_pc = head_pc + XLEN'(PC_STEP);
        end
    end

    // NOTE: the storage array has no reset; an entry is only ever read after
    // it has been written, and leaving it unreset keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            mem_data[wr_ptr] <= in_data;
            mem_pc[wr_ptr]   <= in_pc;
            mem_ir[wr_ptr]   <= in_ir;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Retire outputs: pulses are set only in the cycle after a pop, data-like
    // outputs hold their last value otherwise.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rf_we     <= 1'b0;
            rf_rd     <= '0;
            rf_wd     <= '0;
            pc_valid  <= 1'b0;
            pc_o      <= '0;
            illegal_o <= 1'b0;
        end else begin
            rf_we     <= pop && head_we;
            pc_valid  <= pop;
            illegal_o <= pop && !head_legal;
            if (pop) begin
                rf_rd <= head_ir[11:7];
                rf_wd <= head_data;
                pc_o  <= head_next_pc;
            end
        end
    end

`ifdef WB_RETIRE_CNT_EN
    // Survives flush; only reset clears it.
    always_ff @(posedge clk) begin
        if (!reset)   retired_o <= '0;
        else if (pop) retired_o <= retired_o + 32'd1;
    end
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// -----------------------------------------------------------------------------
// tb_writeback_unit
//
// Directed self-checking bench for writeback_unit with default parameters
// (XLEN=32, DEPTH=4, PC_STEP=1). Inputs change 1 time unit after a rising
// edge; outputs are sampled at that same point, after registered updates.
// Exercises WB_RETIRE_CNT_EN behaviour when that macro is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [31:0] in_pc;
    logic [31:0] in_ir;
    logic        rf_stall;
    logic        flush;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wd;
    logic        pc_valid;
    logic [31:0] pc_o;
    logic        illegal_o;
    logic [2:0]  count;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retired_o;
`endif

    int checks = 0;
    int errors = 0;

    writeback_unit #(.XLEN(32), .DEPTH(4), .PC_STEP(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_pc     (in_pc),
        .in_ir     (in_ir),
        .rf_stall  (rf_stall),
        .flush     (flush),
        .rf_we     (rf_we),
        .rf_rd     (rf_rd),
        .rf_wd     (rf_wd),
        .pc_valid  (pc_valid),
        .pc_o      (pc_o),
        .illegal_o (illegal_o),
`ifdef WB_RETIRE_CNT_EN
        .retired_o (retired_o),
`endif
        .count     (count)
    );

    always #5 clk = ~clk;

    // Watchdog: the sequence is fixed-length, this only guards against a hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one entry for exactly one edge.
    task automatic push_one(input logic [31:0] ir, input logic [31:0] data, input logic [31:0] pc);
        in_valid = 1'b1;
        in_ir    = ir;
        in_data  = data;
        in_pc    = pc;
        tick();
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] r_type(input logic [4:0] rd);
        return 32'h0000_0033 | (32'(rd) << 7);
    endfunction

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_pc    = '0;
        in_ir    = '0;
        rf_stall = 1'b0;
        flush    = 1'b0;

        // Reset then idle
        tick();
        tick();
        check("rst_rf_we",     32'(rf_we),     32'd0);
        check("rst_rf_rd",     32'(rf_rd),     32'd0);
        check("rst_rf_wd",     rf_wd,          32'd0);
        check("rst_pc_valid",  32'(pc_valid),  32'd0);
        check("rst_pc_o",      pc_o,           32'd0);
        check("rst_illegal",   32'(illegal_o), 32'd0);
        check("rst_count",     32'(count),     32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        reset = 1'b1;
        tick();
        tick();
        check("idle_rf_we",    32'(rf_we),     32'd0);
        check("idle_pc_valid", 32'(pc_valid),  32'd0);
        check("idle_count",    32'(count),     32'd0);

        // Single R-type: add x10 -- two edges from push to visible outputs
        push_one(32'h00B5_0533, 32'h0000_1234, 32'h0000_0010);
        check("r_count_after_push", 32'(count),    32'd1);
        check("r_no_early_retire",  32'(pc_valid), 32'd0);
        tick();
        check("r_rf_we",    32'(rf_we),     32'd1);
        check("r_rf_rd",    32'(rf_rd),     32'd10);
        check("r_rf_wd",    rf_wd,          32'h0000_1234);
        check("r_pc_valid", 32'(pc_valid),  32'd1);
        check("r_pc_o",     pc_o,           32'h0000_0011);
        check("r_illegal",  32'(illegal_o), 32'd0);
        check("r_count",    32'(count),     32'd0);
        tick();
        check("r_we_pulse",    32'(rf_we),    32'd0);
        check("r_valid_pulse", 32'(pc_valid), 32'd0);
        check("r_rd_hold",     32'(rf_rd),    32'd10);
        check("r_pc_hold",     pc_o,          32'h0000_0011);

        // I-type with rd = x0: no write, PC still advances
        push_one(32'h0000_0013, 32'h0000_0055, 32'h0000_0020);
        tick();
        check("i0_rf_we",    32'(rf_we),     32'd0);
        check("i0_pc_valid", 32'(pc_valid),  32'd1);
        check("i0_pc_o",     pc_o,           32'h0000_0021);
        check("i0_illegal",  32'(illegal_o), 32'd0);

        // Branch opcode 0x63 is unsupported
        push_one(32'h0000_0063, 32'h0000_0077, 32'h0000_0030);
        tick();
        check("ill_rf_we",    32'(rf_we),     32'd0);
        check("ill_pc_valid", 32'(pc_valid),  32'd1);
        check("ill_pc_o",     pc_o,           32'd0);
        check("ill_illegal",  32'(illegal_o), 32'd1);
        tick();
        check("ill_pulse_end", 32'(illegal_o), 32'd0);

        // Backpressure: 5 back-to-back offers under stall, only 4 fit
        rf_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_ready_%0d", i), 32'(in_ready), (i < 4) ? 32'd1 : 32'd0);
            in_valid = 1'b1;
            in_ir    = r_type(5'(i + 1));
            in_data  = 32'h100 + 32'(i);
            in_pc    = 32'h40 + 32'(i);
            tick();
            check($sformatf("bp_stall_valid_%0d", i), 32'(pc_valid), 32'd0);
        end
        in_valid = 1'b0;
        check("bp_count_full", 32'(count),    32'd4);
        check("bp_ready_full", 32'(in_ready), 32'd0);
        // Releasing the stall must not combinationally raise in_ready
        rf_stall = 1'b0;
        #1;
        check("bp_no_bypass", 32'(in_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("bp_valid_%0d", i), 32'(pc_valid), 32'd1);
            check($sformatf("bp_rd_%0d", i),    32'(rf_rd),    32'(i + 1));
            check($sformatf("bp_wd_%0d", i),    rf_wd,         32'h100 + 32'(i));
            check($sformatf("bp_pc_%0d", i),    pc_o,          32'h41 + 32'(i));
        end
        check("bp_count_empty", 32'(count), 32'd0);
        tick();
        check("bp_drained", 32'(pc_valid), 32'd0);

        // Flush: 3 queued plus a simultaneous push, none may retire
        rf_stall = 1'b1;
        for (int i = 0; i < 3; i++) push_one(r_type(5'd7), 32'h200 + 32'(i), 32'h60 + 32'(i));
        check("fl_count_3", 32'(count), 32'd3);
        in_valid = 1'b1;
        in_ir    = r_type(5'd8);
        in_data  = 32'h0000_0300;
        in_pc    = 32'h0000_0070;
        flush    = 1'b1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        rf_stall = 1'b0;
        check("fl_count_0",  32'(count),    32'd0);
        check("fl_ready",    32'(in_ready), 32'd1);
        check("fl_no_pulse", 32'(pc_valid), 32'd0);
        tick();
        check("fl_no_retire", 32'(pc_valid), 32'd0);
        check("fl_still_0",   32'(count),    32'd0);

        // PC wrap
        push_one(r_type(5'd5), 32'h0000_00AA, 32'hFFFF_FFFF);
        tick();
        check("wrap_valid", 32'(pc_valid), 32'd1);
        check("wrap_we",    32'(rf_we),    32'd1);
        check("wrap_pc_o",  pc_o,          32'h0000_0000);

        // Reset in the middle of operation clears occupancy and outputs
        rf_stall = 1'b1;
        push_one(r_type(5'd3), 32'h0000_0011, 32'h0000_0080);
        push_one(r_type(5'd4), 32'h0000_0022, 32'h0000_0081);
        check("mid_count_2", 32'(count), 32'd2);
        reset = 1'b0;
        in_valid = 1'b1;
        flush = 1'b1;
        tick();
        in_valid = 1'b0;
        flush = 1'b0;
        reset = 1'b1;
        rf_stall = 1'b0;
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_rf_rd", 32'(rf_rd), 32'd0);
        check("mid_rst_rf_wd", rf_wd,      32'd0);
        check("mid_rst_pc_o",  pc_o,       32'd0);
        tick();
        check("mid_rst_idle", 32'(pc_valid), 32'd0);

`ifdef WB_RETIRE_CNT_EN
        check("cnt_after_reset", retired_o, 32'd0);
        in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_ir   = r_type(5'(i + 1));
            in_data = 32'(i);
            in_pc   = 32'h100 + 32'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("cnt_7_after_flush", retired_o, 32'd7);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("cnt_cleared", retired_o, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
